// File: rtl/pulp_icache_fetch_arb_pkg.sv
// Shared types and helpers for the icache fetch-port arbiter.
package pulp_icache_fetch_arb_pkg;

  localparam int unsigned PerfCntWidth  = 16;
  localparam int unsigned DefaultNumReq = 4;

  // Index width for n entries; a single entry still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_width(DefaultNumReq)-1:0] idx_t;

  typedef enum logic {
    LockIdle = 1'b0,
    LockHeld = 1'b1
  } lock_state_e;

endpackage

// File: rtl/pulp_icache_fetch_arb_id_fifo.sv
// In-order FIFO of requester indices for granted-but-unanswered fetches.
// Registered head only (no fall-through); synchronous active-high reset.
module pulp_icache_fetch_arb_id_fifo
  import pulp_icache_fetch_arb_pkg::*;
#(
  parameter int unsigned Width = $bits(idx_t),
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pulp_icache_fetch_arb.sv
// Round-robin arbiter sharing one icache fetch port between NumReq requesters.
// Optional stall counters are built when PULP_ICACHE_FETCH_ARB_PERF_EN is defined.
module pulp_icache_fetch_arb
  import pulp_icache_fetch_arb_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [NumReq-1:0][DataWidth-1:0]     rdata_o,
  output logic [NumReq-1:0]                    rerror_o,
  output logic                                 cache_req_o,
  output logic [AddrWidth-1:0]                 cache_addr_o,
  input  logic                                 cache_gnt_i,
  input  logic                                 cache_rvalid_i,
  input  logic [DataWidth-1:0]                 cache_rdata_i,
  input  logic                                 cache_rerror_i,
  output logic                                 proto_err_o
`ifdef PULP_ICACHE_FETCH_ARB_PERF_EN
  ,
  input  logic                                 clr_cnt_i,
  output logic [NumReq-1:0][PerfCntWidth-1:0] stall_cnt_o
`endif
);

  localparam int unsigned IdxW = idx_width(NumReq);
  typedef logic [IdxW-1:0] req_idx_t;

  // Handshake semantics on both sides: a transfer happens in the cycle where
  // req and gnt are both high; rvalid is a one-cycle pulse, in issue order.
  lock_state_e      lock_state_q;
  req_idx_t         lock_idx_q;
  req_idx_t         rr_q;
  logic             proto_err_q;

  req_idx_t         winner, cand, sel, head;
  logic             found, locked, avail, handshake, pop, spurious;
  logic             fifo_full, fifo_empty;
  logic [NumReq-1:0] sel_oh, head_oh;

  assign locked = (lock_state_q == LockHeld);

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    winner = rr_q;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = req_idx_t'((32'(rr_q) + i) % NumReq);
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign sel       = locked ? lock_idx_q : winner;
  assign avail     = ~fifo_full;
  assign handshake = cache_req_o & cache_gnt_i;
  assign pop       = ~rst_i & cache_rvalid_i & ~fifo_empty;
  assign spurious  = cache_rvalid_i & fifo_empty;

  always_comb begin
    sel_oh       = '0;
    sel_oh[sel]  = 1'b1;
    head_oh      = '0;
    head_oh[head] = 1'b1;
  end

  assign cache_req_o  = ~rst_i & avail & (locked | (|req_i));
  assign cache_addr_o = rst_i ? '0 : addr_i[sel];
  assign gnt_o        = handshake ? sel_oh : '0;
  assign rvalid_o     = pop ? head_oh : '0;
  assign rerror_o     = (pop & cache_rerror_i) ? head_oh : '0;
  assign proto_err_o  = proto_err_q;

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      rdata_o[i] = rst_i ? '0 : cache_rdata_i;
    end
  end

  pulp_icache_fetch_arb_id_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (sel),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  // Lock keeps an ungranted request stable; a requester dropping it releases.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_state_q <= LockIdle;
      lock_idx_q   <= '0;
      rr_q         <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      if (spurious) begin
        proto_err_q <= 1'b1;
      end
      if (handshake) begin
        rr_q         <= (sel == req_idx_t'(NumReq - 1)) ? '0 : sel + 1'b1;
        lock_state_q <= LockIdle;
      end else if (locked && !req_i[lock_idx_q]) begin
        lock_state_q <= LockIdle;
      end else if (cache_req_o && !cache_gnt_i) begin
        lock_state_q <= LockHeld;
        lock_idx_q   <= sel;
      end
    end
  end

`ifdef PULP_ICACHE_FETCH_ARB_PERF_EN
  logic [NumReq-1:0][PerfCntWidth-1:0] stall_cnt_q;

  // Clear has priority over counting; counters saturate at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (req_i[i] && !gnt_o[i] && (stall_cnt_q[i] != '1)) begin
          stall_cnt_q[i] <= stall_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pulp_icache_fetch_arb.sv
// Directed bench for pulp_icache_fetch_arb with a response scoreboard.
// Stall counter steps run when PULP_ICACHE_FETCH_ARB_PERF_EN is defined.
module tb_pulp_icache_fetch_arb;

  localparam int unsigned NumReq = 4;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned W      = NumReq;

  logic                        clk, rst;
  logic [NumReq-1:0]           req;
  logic [NumReq-1:0][AW-1:0]   addr;
  logic [NumReq-1:0]           gnt, rvalid, rerror;
  logic [NumReq-1:0][DW-1:0]   rdata;
  logic                        cache_req, cache_gnt, cache_rvalid, cache_rerror, proto_err;
  logic [AW-1:0]               cache_addr;
  logic [DW-1:0]               cache_rdata;
`ifdef PULP_ICACHE_FETCH_ARB_PERF_EN
  logic                        clr_cnt;
  logic [NumReq-1:0][15:0]     stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  pulp_icache_fetch_arb #(
    .NumReq(NumReq), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .gnt_o(gnt),
    .rvalid_o(rvalid), .rdata_o(rdata), .rerror_o(rerror),
    .cache_req_o(cache_req), .cache_addr_o(cache_addr), .cache_gnt_i(cache_gnt),
    .cache_rvalid_i(cache_rvalid), .cache_rdata_i(cache_rdata),
    .cache_rerror_i(cache_rerror), .proto_err_o(proto_err)
`ifdef PULP_ICACHE_FETCH_ARB_PERF_EN
    , .clr_cnt_i(clr_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req          = '0;
    cache_gnt    = 1'b0;
    cache_rvalid = 1'b0;
    cache_rdata  = '0;
    cache_rerror = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver for a cache response
  task automatic respond(input logic [DW-1:0] data, input logic err);
    cache_rvalid = 1'b1;
    cache_rdata  = data;
    cache_rerror = err;
  endtask

  // Scoreboard: compare the routed response against the oldest expected grant
  task automatic check_resp(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rvalid"}, rvalid, e);
      check({tag, "_rerror"}, rerror, cache_rerror ? e : '0);
      check({tag, "_rdata"}, rdata, {NumReq{cache_rdata}});
    end
  endtask

  initial begin
    logic [W-1:0] eg;
    addr = '0;
`ifdef PULP_ICACHE_FETCH_ARB_PERF_EN
    clr_cnt = 1'b0;
`endif
    // Reset with busy inputs: everything stays quiet
    rst = 1'b1;
    req = '1;
    cache_gnt = 1'b1;
    cache_rvalid = 1'b1;
    cache_rdata = 32'h1234_5678;
    cache_rerror = 1'b0;
    to_check();
    check("rst_gnt", gnt, '0);
    check("rst_cache_req", cache_req, 1'b0);
    check("rst_rvalid", rvalid, '0);
    check("rst_proto_err", proto_err, 1'b0);
    next();
    idle_inputs();
    rst = 1'b0;
    to_check();
    check("idle_cache_req", cache_req, 1'b0);
    check("idle_proto_err", proto_err, 1'b0);
    next();

    // Single requester
    req = 4'b0010;
    addr[1] = 32'h100;
    cache_gnt = 1'b1;
    exp_q.push_back(4'b0010);
    to_check();
    check("single_cache_req", cache_req, 1'b1);
    check("single_addr", cache_addr, 32'h100);
    check("single_gnt", gnt, 4'b0010);
    next();
    idle_inputs();
    respond(32'hDEAD_BEEF, 1'b0);
    to_check();
    check_resp("single");
    check("single_proto_err", proto_err, 1'b0);
    next();

    // Fairness with all requesters active
    do_reset();
    req = 4'b1111;
    cache_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      eg = W'(1) << (k % 4);
      exp_q.push_back(eg);
      if (k > 0) respond(DW'($urandom), 1'($urandom_range(0, 1)));
      to_check();
      check($sformatf("fair_gnt%0d", k), gnt, eg);
      if (k > 0) check_resp($sformatf("fair_resp%0d", k));
      next();
    end
    req = '0;
    cache_gnt = 1'b0;
    respond(DW'($urandom), 1'b1);
    to_check();
    check_resp("fair_drain");
    next();
    idle_inputs();

    // Lock holds the request stable while the cache stalls
    do_reset();
    req = 4'b0001;
    addr[0] = 32'h40;
    addr[1] = 32'h80;
    cache_gnt = 1'b1;
    exp_q.push_back(4'b0001);
    to_check();
    check("lock_pre_gnt", gnt, 4'b0001);
    next();
    cache_gnt = 1'b0;
    respond(32'hA5A5_0000, 1'b0);
    to_check();
    check("lock_c0_addr", cache_addr, 32'h40);
    check("lock_c0_gnt", gnt, '0);
    check_resp("lock_pre");
    next();
    cache_rvalid = 1'b0;
    req = 4'b0011;
    for (int k = 1; k < 3; k++) begin
      to_check();
      check($sformatf("lock_c%0d_req", k), cache_req, 1'b1);
      check($sformatf("lock_c%0d_addr", k), cache_addr, 32'h40);
      check($sformatf("lock_c%0d_gnt", k), gnt, '0);
      next();
    end
    cache_gnt = 1'b1;
    exp_q.push_back(4'b0001);
    to_check();
    check("lock_release_gnt", gnt, 4'b0001);
    next();
    exp_q.push_back(4'b0010);
    respond(32'h0000_0040, 1'b0);
    to_check();
    check("lock_next_gnt", gnt, 4'b0010);
    check("lock_next_addr", cache_addr, 32'h80);
    check_resp("lock_r0");
    next();
    req = '0;
    cache_gnt = 1'b0;
    respond(32'h0000_0080, 1'b1);
    to_check();
    check_resp("lock_r1");
    next();
    idle_inputs();

    // Full FIFO blocks further grants until a pop has taken effect
    do_reset();
    cache_gnt = 1'b1;
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    to_check();
    check("full_gnt2", gnt, 4'b0100);
    next();
    req = 4'b1000;
    exp_q.push_back(4'b1000);
    to_check();
    check("full_gnt3", gnt, 4'b1000);
    next();
    req = 4'b0001;
    to_check();
    check("full_c2_req", cache_req, 1'b0);
    check("full_c2_gnt", gnt, '0);
    next();
    respond(32'h2222_2222, 1'b0);
    to_check();
    check("full_c3_req", cache_req, 1'b0);
    check("full_c3_gnt", gnt, '0);
    check_resp("full_r2");
    next();
    respond(32'h3333_3333, 1'b1);
    exp_q.push_back(4'b0001);
    to_check();
    check("full_c4_gnt", gnt, 4'b0001);
    check_resp("full_r3");
    next();
    req = '0;
    cache_gnt = 1'b0;
    respond(32'h0000_0001, 1'b0);
    to_check();
    check_resp("full_r0");
    next();
    idle_inputs();

    // Spurious response sets the sticky protocol error
    do_reset();
    respond(32'hBAD0_BAD0, 1'b1);
    to_check();
    check("spur_rvalid", rvalid, '0);
    check("spur_rerror", rerror, '0);
    check("spur_err_before", proto_err, 1'b0);
    next();
    idle_inputs();
    to_check();
    check("spur_err_set", proto_err, 1'b1);
    next();
    next();
    to_check();
    check("spur_err_sticky", proto_err, 1'b1);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    to_check();
    check("spur_err_cleared", proto_err, 1'b0);
    next();

`ifdef PULP_ICACHE_FETCH_ARB_PERF_EN
    // Requester 3 waits behind locked requester 0
    do_reset();
    req = 4'b1001;
    addr[0] = 32'h40;
    for (int k = 0; k < 5; k++) next();
    req = '0;
    to_check();
    check("perf_stall3", stall_cnt[3], 16'd5);
    check("perf_stall0", stall_cnt[0], 16'd5);
    check("perf_stall1", stall_cnt[1], 16'd0);
    next();
    clr_cnt = 1'b1;
    next();
    clr_cnt = 1'b0;
    to_check();
    check("perf_clr3", stall_cnt[3], 16'd0);
    next();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
